pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Consumes the load-use hazard flag from the EX-stage forwarding unit, I/D-cache handshake status and the EX-stage branch redirect.
- Drives per-stage pipeline-register load enables and bubble inserts, and keeps saturating stall/flush performance counters.
- Sits between the forwarding unit, both cache ports and every pipeline register.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Drives register enables and bubbles, and keeps perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdata_hazard,
  input  logic             icache_resp,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic             dcache_resp,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_if_id,
  output logic             bubble_id_ex,
  output logic             bubble_ex_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fsm_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  fsm_e             fsm_q, fsm_d;
  logic             lu_done_q, lu_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] lucnt_q, lucnt_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic dstall, istall, lu, disc;
  logic r_frz, r_lu, r_br, r_if;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic bb_ifid, bb_idex, bb_exmem;
  logic stall_ev;

  assign dstall = (dcache_read | dcache_write) & ~dcache_resp;
  assign istall = ~icache_resp;
  assign lu     = rdata_hazard & ~lu_done_q;
  assign disc   = (fsm_q == DISCARD);

  // Priority decode: freeze, load-use, redirect, fetch hold.
  assign r_frz = dstall;
  assign r_lu  = ~dstall & lu;
  assign r_br  = ~dstall & ~lu & br_taken;
  assign r_if  = ~dstall & ~lu & ~br_taken & (istall | disc);

  // Per-rule enables and bubbles for each pipeline register.
  always_comb begin
    en_pc    = 1'b1;
    en_ifid  = 1'b1;
    en_idex  = 1'b1;
    en_exmem = 1'b1;
    en_memwb = 1'b1;
    bb_ifid  = 1'b0;
    bb_idex  = 1'b0;
    bb_exmem = 1'b0;
    unique case (1'b1)
      r_frz: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        en_exmem = 1'b0;
        en_memwb = 1'b0;
      end
      r_lu: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        bb_exmem = 1'b1;
      end
      r_br: begin
        bb_ifid = 1'b1;
        bb_idex = 1'b1;
      end
      r_if: begin
        en_pc   = 1'b0;
        bb_ifid = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_ev = ~(en_pc & en_ifid & en_idex & en_exmem & en_memwb);

  // Outputs are forced idle while reset is held.
  assign load_pc       = rst_n & en_pc;
  assign load_if_id    = rst_n & en_ifid;
  assign load_id_ex    = rst_n & en_idex;
  assign load_ex_mem   = rst_n & en_exmem;
  assign load_mem_wb   = rst_n & en_memwb;
  assign bubble_if_id  = rst_n & bb_ifid;
  assign bubble_id_ex  = rst_n & bb_idex;
  assign bubble_ex_mem = rst_n & bb_exmem;

  assign stall_cnt   = stall_q;
  assign loaduse_cnt = lucnt_q;
  assign flush_cnt   = flush_q;

  // Next state: discard tracking, one-shot load-use flag, counters.
  always_comb begin
    fsm_d = fsm_q;
    if (r_br) begin
      fsm_d = (istall | disc) ? DISCARD : RUN;
    end else if (r_if && disc && icache_resp) begin
      fsm_d = RUN;
    end

    lu_done_d = 1'b0;
    if (r_frz) begin
      lu_done_d = lu_done_q;
    end else if (r_lu) begin
      lu_done_d = 1'b1;
    end

    stall_d = stall_q;
    if (stall_ev && stall_q != MAX) begin
      stall_d = stall_q + ONE;
    end
    lucnt_d = lucnt_q;
    if (r_lu && lucnt_q != MAX) begin
      lucnt_d = lucnt_q + ONE;
    end
    flush_d = flush_q;
    if (r_br && flush_q != MAX) begin
      flush_d = flush_q + ONE;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= RUN;
      lu_done_q <= 1'b0;
      stall_q   <= '0;
      lucnt_q   <= '0;
      flush_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      lu_done_q <= lu_done_d;
      stall_q   <= stall_d;
      lucnt_q   <= lucnt_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl.
// Narrow counters let saturation be reached quickly.
module tb_pipeline_hazard_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rh, ir, dr, dw, dresp, br;
  logic ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb;
  logic bb_ifid, bb_idex, bb_exmem;
  logic [W-1:0] s_cnt, l_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdata_hazard (rh),
    .icache_resp  (ir),
    .dcache_read  (dr),
    .dcache_write (dw),
    .dcache_resp  (dresp),
    .br_taken     (br),
    .load_pc      (ld_pc),
    .load_if_id   (ld_ifid),
    .load_id_ex   (ld_idex),
    .load_ex_mem  (ld_exmem),
    .load_mem_wb  (ld_memwb),
    .bubble_if_id (bb_ifid),
    .bubble_id_ex (bb_idex),
    .bubble_ex_mem(bb_exmem),
    .stall_cnt    (s_cnt),
    .loaduse_cnt  (l_cnt),
    .flush_cnt    (f_cnt)
  );

  typedef struct {
    logic [5:0]   in;
    logic [4:0]   ld;
    logic [2:0]   bb;
    logic [W-1:0] s;
    logic [W-1:0] l;
    logic [W-1:0] f;
  } vec_t;

  localparam int N = 26;
  vec_t tbl [N];

  function automatic vec_t mk(logic [5:0] i, logic [4:0] l,
                              logic [2:0] b, int sc, int lc, int fc);
    vec_t v;
    v.in = i;
    v.ld = l;
    v.bb = b;
    v.s  = W'(sc);
    v.l  = W'(lc);
    v.f  = W'(fc);
    return v;
  endfunction

  task automatic drive(logic [5:0] i);
    {rh, ir, dr, dw, dresp, br} = i;
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [4:0] l, logic [2:0] b);
    chk({nm, ".load"},
        int'({ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb}), int'(l));
    chk({nm, ".bubble"}, int'({bb_ifid, bb_idex, bb_exmem}), int'(b));
  endtask

  task automatic chk_cnt(string nm, int sc, int lc, int fc);
    chk({nm, ".stall_cnt"}, int'(s_cnt), sc);
    chk({nm, ".loaduse_cnt"}, int'(l_cnt), lc);
    chk({nm, ".flush_cnt"}, int'(f_cnt), fc);
  endtask

  // in = {rdata_hazard, icache_resp, dread, dwrite, dresp, br}
  localparam logic [5:0] IDLE = 6'b010000;

  initial begin
    // load-use, hazard held two cycles
    tbl[0]  = mk(IDLE,      5'b11111, 3'b000, 0, 0, 0);
    tbl[1]  = mk(6'b110000, 5'b00011, 3'b001, 0, 0, 0);
    tbl[2]  = mk(6'b110000, 5'b11111, 3'b000, 1, 1, 0);
    tbl[3]  = mk(IDLE,      5'b11111, 3'b000, 1, 1, 0);
    // d-miss four cycles, then resp
    tbl[4]  = mk(6'b011000, 5'b00000, 3'b000, 1, 1, 0);
    tbl[5]  = mk(6'b011000, 5'b00000, 3'b000, 2, 1, 0);
    tbl[6]  = mk(6'b011000, 5'b00000, 3'b000, 3, 1, 0);
    tbl[7]  = mk(6'b011000, 5'b00000, 3'b000, 4, 1, 0);
    tbl[8]  = mk(6'b011010, 5'b11111, 3'b000, 5, 1, 0);
    // branch with ready fetch
    tbl[9]  = mk(6'b010001, 5'b11111, 3'b110, 5, 1, 0);
    tbl[10] = mk(IDLE,      5'b11111, 3'b000, 5, 1, 1);
    // branch during i-miss, resp after three cycles
    tbl[11] = mk(6'b000001, 5'b11111, 3'b110, 5, 1, 1);
    tbl[12] = mk(6'b000000, 5'b01111, 3'b100, 5, 1, 2);
    tbl[13] = mk(6'b000000, 5'b01111, 3'b100, 6, 1, 2);
    tbl[14] = mk(6'b000000, 5'b01111, 3'b100, 7, 1, 2);
    tbl[15] = mk(6'b010000, 5'b01111, 3'b100, 8, 1, 2);
    tbl[16] = mk(IDLE,      5'b11111, 3'b000, 9, 1, 2);
    // store miss + hazard + branch together
    tbl[17] = mk(6'b110101, 5'b00000, 3'b000, 9, 1, 2);
    tbl[18] = mk(6'b110101, 5'b00000, 3'b000, 10, 1, 2);
    tbl[19] = mk(6'b110111, 5'b00011, 3'b001, 11, 1, 2);
    tbl[20] = mk(6'b110001, 5'b11111, 3'b110, 12, 2, 2);
    tbl[21] = mk(IDLE,      5'b11111, 3'b000, 12, 2, 3);
    // lu_done survives a freeze: only one bubble
    tbl[22] = mk(6'b110000, 5'b00011, 3'b001, 12, 2, 3);
    tbl[23] = mk(6'b111000, 5'b00000, 3'b000, 13, 3, 3);
    tbl[24] = mk(6'b110000, 5'b11111, 3'b000, 14, 3, 3);
    tbl[25] = mk(IDLE,      5'b11111, 3'b000, 14, 3, 3);

    rst_n = 1'b0;
    drive(IDLE);
    @(negedge clk);
    #2;
    chk_out("in_reset", 5'b00000, 3'b000);
    chk_cnt("in_reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #2;
      chk_out($sformatf("row%0d", i), tbl[i].ld, tbl[i].bb);
      chk_cnt($sformatf("row%0d", i),
              int'(tbl[i].s), int'(tbl[i].l), int'(tbl[i].f));
    end

    // saturation: stall count is 14, push well past all-ones
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(6'b011000);
      #2;
      chk_out($sformatf("sat%0d", i), 5'b00000, 3'b000);
    end
    chk_cnt("sat_hold", 15, 3, 3);
    @(negedge clk);
    drive(IDLE);
    #2;
    chk_cnt("sat_stay", 15, 3, 3);

    // enter DISCARD then reset in the middle of it
    @(negedge clk);
    drive(6'b000001);
    #2;
    chk_out("disc_br", 5'b11111, 3'b110);
    @(negedge clk);
    drive(6'b000000);
    #2;
    chk_out("disc_wait", 5'b01111, 3'b100);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_out("mid_reset", 5'b00000, 3'b000);
    chk_cnt("mid_reset", 0, 0, 0);
    @(negedge clk);
    drive(IDLE);
    rst_n = 1'b1;
    #2;
    chk_out("post_reset", 5'b11111, 3'b000);
    chk_cnt("post_reset", 0, 0, 0);
    @(negedge clk);
    #2;
    chk_out("post_reset2", 5'b11111, 3'b000);
    chk_cnt("post_reset2", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
